// File: rtl/spi_rdid_capture.sv
// Oversampling SPI receiver that skips the RDID opcode and captures the JEDEC ID behind a valid/ready handshake.
// Optional build macro RDID_CHECK_EN adds id_match, a registered compare against EXPECTED_ID.
module spi_rdid_capture #(
    parameter int                   CMD_BITS    = 8,
    parameter int                   DATA_BITS   = 24,
    parameter logic [DATA_BITS-1:0] EXPECTED_ID = DATA_BITS'(24'h20BA18)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_cs,
    input  logic                 spi_sclk,
    input  logic                 spi_miso,
    output logic [DATA_BITS-1:0] id_data,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef RDID_CHECK_EN
    output logic                 id_match,
`endif
    output logic [2:0]           state_dbg
);

    localparam int MAX_BITS = (CMD_BITS > DATA_BITS) ? CMD_BITS : DATA_BITS;
    localparam int CW       = $clog2(MAX_BITS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SKIP    = 3'd1,
        SHIFT   = 3'd2,
        DONE    = 3'd3,
        WAIT_CS = 3'd4
    } state_t;

    state_t               state;
    logic [CW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 cs_s1, cs_s2;
    logic                 sclk_s1, sclk_s2, sclk_s3;
    logic                 miso_s1, miso_s2;
    logic                 rise;

    assign state_dbg = state;
    assign rise      = sclk_s2 & ~sclk_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            cs_s1   <= spi_cs;
            cs_s2   <= cs_s1;
            sclk_s1 <= spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            miso_s1 <= spi_miso;
            miso_s2 <= miso_s1;
        end
    end

    // Handshake (valid/ready): id_data transfers on any clk edge where id_valid
    // and id_ready are both 1; id_data and id_valid hold otherwise. A commit in
    // the transfer cycle reloads id_data and keeps id_valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            id_data   <= '0;
            id_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef RDID_CHECK_EN
            id_match  <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            if (id_valid && id_ready) id_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_s2) begin
                        state   <= SKIP;
                        bit_cnt <= '0;
                    end
                end
                SKIP: begin
                    if (!cs_s2) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (rise) begin
                        if (bit_cnt == CW'(CMD_BITS - 1)) begin
                            state   <= SHIFT;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (!cs_s2) begin
                        frame_err <= 1'b1;
                        shreg     <= '0;
                        state     <= IDLE;
                    end else if (rise) begin
                        shreg <= DATA_BITS'({shreg, miso_s2});
                        if (bit_cnt == CW'(DATA_BITS - 1)) begin
                            state <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // An unread result wins over the new one; the loss is recorded.
                    if (!id_valid || id_ready) begin
                        id_data  <= shreg;
                        id_valid <= 1'b1;
`ifdef RDID_CHECK_EN
                        id_match <= (shreg == EXPECTED_ID);
`endif
                    end else begin
                        overrun <= 1'b1;
                    end
                    state <= WAIT_CS;
                end
                WAIT_CS: begin
                    if (!cs_s2) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rdid_capture.sv
// Directed bench for spi_rdid_capture: bit-banged RDID frames with hand-computed IDs.
// Define RDID_CHECK_EN at compile time to also exercise the id_match compare.
module tb_spi_rdid_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_cs = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_miso = 1'b0;
    logic [23:0] id_data;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic        frame_err;
    logic        overrun;
`ifdef RDID_CHECK_EN
    logic        id_match;
`endif
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;

    spi_rdid_capture dut (
        .clk       (clk),
        .reset     (reset),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_miso  (spi_miso),
        .id_data   (id_data),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef RDID_CHECK_EN
        .id_match  (id_match),
`endif
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Counts every clk cycle in which frame_err is high.
    always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

    task automatic spi_bit(input logic b);
        @(negedge clk) spi_miso = b;
        repeat (2) @(negedge clk);
        spi_sclk = 1'b1;
        repeat (2) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_cmd();
        logic [7:0] cmd;
        cmd = 8'h9F;
        spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) spi_bit(cmd[7-i]);
    endtask

    // Full frame. Snapshots are taken 3 and 4 clk edges after the final sclk
    // rise; ready_at>0 raises id_ready so it is sampled on edge ready_at only.
    task automatic spi_frame(input logic [23:0] data, input int ready_at,
                             output logic v3, output logic v4,
                             output logic [23:0] d4, output logic ov4);
        spi_cmd();
        for (int i = 0; i < 23; i++) spi_bit(data[23-i]);
        @(negedge clk) spi_miso = data[0];
        repeat (2) @(negedge clk);
        spi_sclk = 1'b1;
        v3 = 1'b0; v4 = 1'b0; d4 = '0; ov4 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 2) spi_sclk = 1'b0;
            if (ready_at > 0 && i == ready_at - 1) id_ready = 1'b1;
            if (ready_at > 0 && i == ready_at) id_ready = 1'b0;
            if (i == 3) v3 = id_valid;
            if (i == 4) begin
                v4  = id_valid;
                d4  = id_data;
                ov4 = overrun;
            end
        end
        spi_cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic drain();
        @(negedge clk) id_ready = 1'b1;
        @(negedge clk) id_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", id_valid); end
        n_checks++; if (id_data !== 24'h0) begin n_fail++; $display("FAIL reset_data got %h want 000000", id_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
        n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_dbg); end
`ifdef RDID_CHECK_EN
        n_checks++; if (id_match !== 1'b0) begin n_fail++; $display("FAIL reset_match got %b want 0", id_match); end
`endif
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        logic v3, v4, ov4;
        logic [23:0] d4;
        int fe0;
        fe0 = fe_cnt;
        spi_frame(24'h20BA18, 0, v3, v4, d4, ov4);
        n_checks++; if (v3 !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early got %b want 0", v3); end
        n_checks++; if (v4 !== 1'b1) begin n_fail++; $display("FAIL basic_valid_lat4 got %b want 1", v4); end
        n_checks++; if (d4 !== 24'h20BA18) begin n_fail++; $display("FAIL basic_data got %h want 20ba18", d4); end
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL basic_frame_err got %0d want 0", fe_cnt - fe0); end
        n_checks++; if (id_data !== 24'h20BA18 || id_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hold got %h/%b want 20ba18/1", id_data, id_valid); end
    endtask

    task automatic test_accept();
        drain();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL accept_valid_drop got %b want 0", id_valid); end
    endtask

    task automatic test_abort();
        logic v3, v4, ov4;
        logic [23:0] d4;
        int fe0;
        spi_cmd();
        for (int i = 0; i < 10; i++) spi_bit(i[0]);
        fe0 = fe_cnt;
        @(negedge clk) spi_cs = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL abort_pulse got %0d cycles want 1", fe_cnt - fe0); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", id_valid); end
        n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL abort_state got %0d want 0", state_dbg); end
        spi_frame(24'hABCDEF, 0, v3, v4, d4, ov4);
        n_checks++; if (v4 !== 1'b1 || d4 !== 24'hABCDEF) begin n_fail++; $display("FAIL abort_next got %h/%b want abcdef/1", d4, v4); end
    endtask

    task automatic test_back_to_back();
        logic v3, v4, ov4;
        logic [23:0] d4;
        spi_frame(24'h5A5AA5, 4, v3, v4, d4, ov4);
        n_checks++; if (v4 !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", v4); end
        n_checks++; if (d4 !== 24'h5A5AA5) begin n_fail++; $display("FAIL b2b_data got %h want 5a5aa5", d4); end
        n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b want 0", ov4); end
        n_checks++; if (id_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_after got %b/%b want 1/0", id_valid, overrun); end
    endtask

    task automatic test_overrun();
        logic v3, v4, ov4;
        logic [23:0] d4;
        drain();
        spi_frame(24'h20BA18, 0, v3, v4, d4, ov4);
        n_checks++; if (v4 !== 1'b1 || ov4 !== 1'b0) begin n_fail++; $display("FAIL ovr_first got %b/%b want 1/0", v4, ov4); end
        spi_frame(24'h123456, 0, v3, v4, d4, ov4);
        n_checks++; if (d4 !== 24'h20BA18) begin n_fail++; $display("FAIL ovr_keep_old got %h want 20ba18", d4); end
        n_checks++; if (ov4 !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", ov4); end
        repeat (20) @(negedge clk);
        drain();
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid_shift();
        logic v3, v4, ov4;
        logic [23:0] d4;
        int fe0;
        spi_cmd();
        for (int i = 0; i < 10; i++) spi_bit(1'b1);
        @(negedge clk);
        n_checks++; if (state_dbg !== 3'd2) begin n_fail++; $display("FAIL rst_in_shift got %0d want 2", state_dbg); end
        fe0 = fe_cnt;
        reset = 1'b1;
        spi_cs = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b want 0", overrun); end
        n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", state_dbg); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        spi_frame(24'hC22017, 0, v3, v4, d4, ov4);
        n_checks++; if (v4 !== 1'b1 || d4 !== 24'hC22017) begin n_fail++; $display("FAIL rst_frame got %h/%b want c22017/1", d4, v4); end
        n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL rst_frame_err got %0d want 0", fe_cnt - fe0); end
    endtask

`ifdef RDID_CHECK_EN
    task automatic test_match();
        logic v3, v4, ov4;
        logic [23:0] d4;
        drain();
        spi_frame(24'h20BA18, 0, v3, v4, d4, ov4);
        n_checks++; if (id_valid !== 1'b1 || id_match !== 1'b1) begin n_fail++; $display("FAIL match_hit got %b/%b want 1/1", id_valid, id_match); end
        drain();
        spi_frame(24'h20BA19, 0, v3, v4, d4, ov4);
        n_checks++; if (id_valid !== 1'b1 || id_match !== 1'b0) begin n_fail++; $display("FAIL match_miss got %b/%b want 1/0", id_valid, id_match); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_accept();
        test_abort();
        test_back_to_back();
        test_overrun();
        test_reset_mid_shift();
`ifdef RDID_CHECK_EN
        test_match();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
